// File: rtl/wcu_pkg.sv
// Shared types and constants for the crosswalk control unit.
// Holds the button channel FSM state encoding and the default debounce length.
package wcu_pkg;

    // Channel state: IDLE (db=0,s=0), ARMING (db=0,s=1),
    // PRESSED (db=1,s=1), RELEASING (db=1,s=0).
    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_ARMING,
        BTN_PRESSED,
        BTN_RELEASING
    } btn_state_t;

    // Consecutive stable synchronised samples needed to accept a level change.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/wcu_btn_channel.sv
// One pedestrian button channel: 2-flop synchroniser, debounce counter,
// channel FSM and press-request latch.
// Ports: clk, reset (async active-low), raw (async button), clr (sync
// request clear), req (latched request flop), db (debounced level flop).
module wcu_btn_channel
    import wcu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic clr,
    output logic req,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s_meta;
    logic          s;
    logic [CW-1:0] cnt;
    btn_state_t    state;
    logic          done;
    logic          press;

    // done: this edge is the one whose increment would reach the limit,
    // so db toggles now and the counter restarts.
    assign done  = (s != db) && (cnt == LAST);
    // Only the rising debounced transition is a press event.
    assign press = done && !db;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
            cnt    <= '0;
            db     <= 1'b0;
            req    <= 1'b0;
            state  <= BTN_IDLE;
        end else begin
            s_meta <= raw;
            s      <= s_meta;

            if (s == db || done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (done) begin
                db <= ~db;
            end

            // Set has priority so a press coinciding with a clear survives.
            if (press) begin
                req <= 1'b1;
            end else if (clr) begin
                req <= 1'b0;
            end

            // With a one-sample debounce the count completes on the
            // first mismatching edge, so IDLE/PRESSED may skip ahead.
            unique case (state)
                BTN_IDLE: begin
                    if (s) begin
                        state <= done ? BTN_PRESSED : BTN_ARMING;
                    end
                end
                BTN_ARMING: begin
                    if (!s) begin
                        state <= BTN_IDLE;
                    end else if (done) begin
                        state <= BTN_PRESSED;
                    end
                end
                BTN_PRESSED: begin
                    if (!s) begin
                        state <= done ? BTN_IDLE : BTN_RELEASING;
                    end
                end
                BTN_RELEASING: begin
                    if (s) begin
                        state <= BTN_PRESSED;
                    end else if (done) begin
                        state <= BTN_IDLE;
                    end
                end
                default: state <= BTN_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wcu_button_conditioner.sv
// Front-end conditioner for the two pedestrian push buttons P and Q.
// Ports: clk, reset (async active-low), p_raw/q_raw (async buttons),
// p_clr/q_clr (sync request clears), p/q (latched requests),
// p_db/q_db (debounced levels). All outputs are flop outputs.
module wcu_button_conditioner
    import wcu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic p_raw,
    input  logic q_raw,
    input  logic p_clr,
    input  logic q_clr,
    output logic p,
    output logic q,
    output logic p_db,
    output logic q_db
);

    wcu_btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) p_chan_inst (
        .clk   (clk),
        .reset (reset),
        .raw   (p_raw),
        .clr   (p_clr),
        .req   (p),
        .db    (p_db)
    );

    wcu_btn_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) q_chan_inst (
        .clk   (clk),
        .reset (reset),
        .raw   (q_raw),
        .clr   (q_clr),
        .req   (q),
        .db    (q_db)
    );

endmodule

// File: doc/wcu_button_conditioner.md
# wcu_button_conditioner

Front-end stage of the crosswalk control unit: takes the two raw, asynchronous, bouncy pedestrian push-button inputs and produces the clean, latched request levels `p` and `q` consumed by `wcu`. Each channel synchronises, debounces, detects the press edge and holds a request until the controller's serve decode clears it. One instance sits in `wcu_top` between the package pins and `wcu_inst`.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples needed to accept a level change. Legal range is 1..255.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `p_raw` input 1: raw button P, asynchronous to `clk`.
- `q_raw` input 1: raw button Q, asynchronous to `clk`.
- `p_clr` input 1: synchronous clear of request P (serve acknowledge from top-level `ts` decode).
- `q_clr` input 1: synchronous clear of request Q.
- `p` output 1: latched request P, drives `wcu.p`.
- `q` output 1: latched request Q, drives `wcu.q`.
- `p_db` output 1: debounced level of P (debug/visibility).
- `q_db` output 1: debounced level of Q.

## Operation
- The two channels are identical and independent; there is no cross-coupling.
- **Synchroniser.** A 2-flop chain on the raw input gives `s`.
- **Debounce counter.** The counter `cnt` has width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Each edge where `s != db`: `cnt` increments.
  - Each edge where `s == db`: `cnt` clears to 0.
  - When the increment would reach `DEBOUNCE_CYCLES`, `db` toggles and `cnt` clears on that same edge.
  - The counter never wraps.
- **Channel FSM states:**
  - IDLE: `db=0`, `s=0`.
  - ARMING: `db=0`, `s=1`, counting.
  - PRESSED: `db=1`, `s=1`.
  - RELEASING: `db=1`, `s=0`, counting.
- **FSM transitions:**
  - IDLE→ARMING on `s=1`.
  - ARMING→IDLE on `s=0`.
  - ARMING→PRESSED on count completion.
  - PRESSED→RELEASING on `s=0`.
  - RELEASING→PRESSED on `s=1`.
  - RELEASING→IDLE on count completion.
- **Press event.** This is a single-cycle internal pulse on ARMING→PRESSED only. A release never generates an event.
- **Request latch.** Set by a press event, cleared by `clr`.
  - If set and clear occur on the same edge, set wins: the new press is not lost.
  - A `clr` while the latch is low has no effect.
  - A held button does not re-set the latch after a clear. A new release/press cycle is required.
- Outputs `p`, `q`, `p_db`, `q_db` are direct flop outputs, with no combinational path from inputs.

## Timing
- **Reset.** While `reset=0`:
  - All flops clear.
  - FSM = IDLE, `cnt=0`.
  - `p=q=p_db=q_db=0`.
  - Assertion mid-debounce or with a request pending discards everything.
  - After release, a button still held low→high is treated as a fresh press and needs the full latency.
- **Press latency.** Take edge 1 as the first rising edge sampling `raw=1`.
  - `s` goes high after edge 2.
  - `db` and the request rise after edge `DEBOUNCE_CYCLES+2`.
- **Release latency.** Symmetric: `db` falls after edge `DEBOUNCE_CYCLES+2`.
- **Glitch rejection.** A raw pulse or dropout shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no `db` change and no request.
- **Clear latency.** `clr` high at edge k → request low after edge k.

## Structure
- Shared package `wcu_pkg` holds:
  - the channel FSM state enum (`BTN_IDLE`, `BTN_ARMING`, `BTN_PRESSED`, `BTN_RELEASING`);
  - the default `DEBOUNCE_CYCLES` constant.
- One sub-module, `wcu_btn_channel`, contains the synchroniser, counter, FSM and request latch.
- The top instantiates `wcu_btn_channel` twice: `p_chan_inst` and `q_chan_inst`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset values.** Reset low for 3 cycles with `p_raw=1` → all outputs 0. After release, `p` rises after edge 6, not earlier.
- **Clean press and clear.** `p_raw` rises before edge 1 and is held → `p_db` and `p` high after edge 6. `p_clr` pulse at edge 10 → `p` low after edge 10 while `p_db` stays 1. No re-assertion while held.
- **Bounce rejection.** `p_raw` toggles 1,0,1,0 on alternate cycles for 12 cycles, then holds 0 → `p`, `p_db` never assert. A 3-cycle high pulse also does not assert them; a 4-cycle high pulse does.
- **Simultaneous set and clear.** Arrange a press event on the same edge as `q_clr=1` while `q=1` from an earlier press → `q` remains 1.
- **Channel independence.** Press P and Q two cycles apart, then clear only Q → `p` stays 1, `q` 0. Each output rises exactly 6 edges after its own raw edge.
- **Reset mid-operation.** Assert reset during ARMING (after edge 4) and again with `q=1` pending → immediate asynchronous clear of all outputs. No residual request after release.
